// File: rtl/xgmii_pkg.sv
// Shared XGMII control characters, idle word and arbiter state encoding.
`default_nettype none

package xgmii_pkg;

  localparam logic [71:0] XGMII_IDLE_WORD = 72'hff_07_07_07_07_07_07_07_07;
  localparam logic [7:0]  START           = 8'hFB;
  localparam logic [7:0]  TERM            = 8'hFD;
  localparam logic [7:0]  IDLE_CHAR       = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/xgmii_frame_detect.sv
// Combinational start/terminate classification of one 72-bit XGMII word.
`default_nettype none

module xgmii_frame_detect
  import xgmii_pkg::*;
(
  input  logic [71:0] i_word,
  output logic        o_is_start,
  output logic        o_is_term
);

  logic [7:0] w_lane_term;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign w_lane_term[gi] = i_word[64+gi] && (i_word[8*gi +: 8] == TERM);
    end
  endgenerate

  assign o_is_start = i_word[64] && (i_word[7:0] == START);
  assign o_is_term  = |w_lane_term;

endmodule

`default_nettype wire

// File: rtl/xgmii_tx_arbiter.sv
// Frame-aware round-robin 2:1 XGMII TX scheduler with inter-frame gap and stray-word drop.
// Optional statistics counters are enabled with XGMII_ARB_STATS_EN.
`default_nettype none

module xgmii_tx_arbiter
  import xgmii_pkg::*;
#(
  parameter int IPG_WORDS = 1,
  parameter int CNT_W     = 16
) (
  input  logic        xgmii_clk,
  input  logic        sys_rst_n,
  input  logic [71:0] src0_dout,
  input  logic        src0_empty,
  output logic        src0_rd_en,
  input  logic [71:0] src1_dout,
  input  logic        src1_empty,
  output logic        src1_rd_en,
  output logic [71:0] dout,
  output logic        empty,
  input  logic        rd_en,
  output logic        busy,
  output logic        drop_pulse
`ifdef XGMII_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] frames0_cnt,
  output logic [CNT_W-1:0] frames1_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] underrun_cnt
`endif
);

  localparam logic [3:0] c_ipg = 4'(IPG_WORDS);

  arb_state_t  r_state;
  logic        r_run;
  logic        r_ptr;
  logic        r_grant;
  logic        r_empty;
  logic        r_busy;
  logic        r_drop;
  logic [71:0] r_dout;
  logic [3:0]  r_gap_cnt;

  logic        w_load;
  logic        w_sel;
  logic        w_sel_empty;
  logic [71:0] w_sel_word;
  logic        w_sel_start;
  logic        w_sel_term;
  logic        w_pop;
  logic [1:0]  w_start;
  logic [1:0]  w_term;
  arb_state_t  w_after_term;
  logic        w_busy_after_term;

  xgmii_frame_detect u_det0 (
    .i_word     (src0_dout),
    .o_is_start (w_start[0]),
    .o_is_term  (w_term[0])
  );

  xgmii_frame_detect u_det1 (
    .i_word     (src1_dout),
    .o_is_start (w_start[1]),
    .o_is_term  (w_term[1])
  );

  assign w_load = r_empty | rd_en;

  // In IDLE the preferred source wins unless it is empty; otherwise the grant is locked.
  always_comb begin
    w_sel = r_grant;
    if (r_state == ST_IDLE) begin
      if (r_ptr ? !src1_empty : !src0_empty) w_sel = r_ptr;
      else                                    w_sel = ~r_ptr;
    end
  end

  assign w_sel_empty = w_sel ? src1_empty : src0_empty;
  assign w_sel_word  = w_sel ? src1_dout  : src0_dout;
  assign w_sel_start = w_start[w_sel];
  assign w_sel_term  = w_term[w_sel];

  // r_run keeps both pops low during reset and the first cycle after release.
  assign w_pop = r_run && w_load && !w_sel_empty &&
                 (r_state == ST_IDLE || r_state == ST_FRAME);

  assign src0_rd_en = w_pop && !w_sel;
  assign src1_rd_en = w_pop &&  w_sel;

  assign w_after_term      = (c_ipg == 4'd0) ? ST_IDLE : ST_GAP;
  assign w_busy_after_term = (c_ipg != 4'd0);

  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_run     <= 1'b0;
      r_ptr     <= 1'b0;
      r_grant   <= 1'b0;
      r_empty   <= 1'b1;
      r_busy    <= 1'b0;
      r_drop    <= 1'b0;
      r_dout    <= XGMII_IDLE_WORD;
      r_gap_cnt <= 4'd0;
    end else begin
      r_run  <= 1'b1;
      r_drop <= 1'b0;
      if (w_load) begin
        r_dout  <= XGMII_IDLE_WORD;
        r_empty <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            if (w_sel_start) begin
              r_grant <= w_sel;
              r_dout  <= w_sel_word;
              r_empty <= 1'b0;
              if (w_sel_term) begin
                r_state   <= w_after_term;
                r_busy    <= w_busy_after_term;
                r_ptr     <= ~w_sel;
                r_gap_cnt <= c_ipg;
              end else begin
                r_state <= ST_FRAME;
                r_busy  <= 1'b1;
              end
            end else begin
              r_drop <= 1'b1;
            end
          end
        end
        ST_FRAME: begin
          if (w_pop) begin
            r_dout  <= w_sel_word;
            r_empty <= 1'b0;
            if (w_sel_term) begin
              r_state   <= w_after_term;
              r_busy    <= w_busy_after_term;
              r_ptr     <= ~r_grant;
              r_gap_cnt <= c_ipg;
            end
          end
        end
        ST_GAP: begin
          if (w_load) begin
            if (r_gap_cnt <= 4'd1) begin
              r_state   <= ST_IDLE;
              r_busy    <= 1'b0;
              r_gap_cnt <= 4'd0;
            end else begin
              r_gap_cnt <= r_gap_cnt - 4'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = r_dout;
  assign empty      = r_empty;
  assign busy       = r_busy;
  assign drop_pulse = r_drop;

`ifdef XGMII_ARB_STATS_EN
  logic r_frames0_unused;
  logic w_term_pop;
  logic w_drop_pop;
  logic w_underrun;

  assign w_term_pop = w_pop && w_sel_term &&
                      (r_state == ST_FRAME || (r_state == ST_IDLE && w_sel_start));
  assign w_drop_pop = w_pop && (r_state == ST_IDLE) && !w_sel_start;
  assign w_underrun = r_run && (r_state == ST_FRAME) && (r_grant ? src1_empty : src0_empty);

  logic [CNT_W-1:0] r_frames0_cnt;
  logic [CNT_W-1:0] r_frames1_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_underrun_cnt;

  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_frames0_cnt  <= '0;
      r_frames1_cnt  <= '0;
      r_drop_cnt     <= '0;
      r_underrun_cnt <= '0;
    end else begin
      if (w_term_pop && !w_sel && (r_frames0_cnt != '1)) r_frames0_cnt <= r_frames0_cnt + 1'b1;
      if (w_term_pop &&  w_sel && (r_frames1_cnt != '1)) r_frames1_cnt <= r_frames1_cnt + 1'b1;
      if (w_drop_pop && (r_drop_cnt != '1))              r_drop_cnt    <= r_drop_cnt + 1'b1;
      if (w_underrun && (r_underrun_cnt != '1))          r_underrun_cnt <= r_underrun_cnt + 1'b1;
    end
  end

  assign frames0_cnt  = r_frames0_cnt;
  assign frames1_cnt  = r_frames1_cnt;
  assign drop_cnt     = r_drop_cnt;
  assign underrun_cnt = r_underrun_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xgmii_tx_arbiter.sv
// Scoreboard bench for xgmii_tx_arbiter: FIFO source models, expected-word queue, negedge monitor.
`default_nettype none

module tb_xgmii_tx_arbiter;

  localparam int IPG = 1;
  localparam logic [71:0] IDLE_W = 72'hff_07_07_07_07_07_07_07_07;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [71:0] s0_dout = IDLE_W, s1_dout = IDLE_W, dout;
  logic        s0_empty = 1'b1, s1_empty = 1'b1;
  logic        s0_rd, s1_rd, empty, rd_en, busy, drop_pulse;
  logic        hold1 = 1'b0;
  logic        p0, p1;

  logic [71:0] q0[$];
  logic [71:0] q1[$];
  logic [71:0] sb[$];

  int n_cmp = 0, n_err = 0;
  int n_drop = 0, exp_drop = 0, n_mid_empty = 0, gap = 0;
  bit in_frame = 0, after_term = 0;

`ifdef XGMII_ARB_STATS_EN
  logic [15:0] f0_cnt, f1_cnt, d_cnt, u_cnt;
`endif

  always #5 clk = ~clk;
  assign rd_en = ~empty;

  xgmii_tx_arbiter #(.IPG_WORDS(IPG), .CNT_W(16)) dut (
    .xgmii_clk  (clk),
    .sys_rst_n  (rst_n),
    .src0_dout  (s0_dout),
    .src0_empty (s0_empty),
    .src0_rd_en (s0_rd),
    .src1_dout  (s1_dout),
    .src1_empty (s1_empty),
    .src1_rd_en (s1_rd),
    .dout       (dout),
    .empty      (empty),
    .rd_en      (rd_en),
    .busy       (busy),
    .drop_pulse (drop_pulse)
`ifdef XGMII_ARB_STATS_EN
    ,
    .frames0_cnt  (f0_cnt),
    .frames1_cnt  (f1_cnt),
    .drop_cnt     (d_cnt),
    .underrun_cnt (u_cnt)
`endif
  );

  function automatic bit tb_is_start(logic [71:0] w);
    return w[64] && (w[7:0] == 8'hFB);
  endfunction

  function automatic bit tb_is_term(logic [71:0] w);
    bit r = 1'b0;
    for (int i = 0; i < 8; i++) if (w[64+i] && (w[8*i +: 8] == 8'hFD)) r = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic chk_ge(input string name, input int got, input int min);
    n_cmp++;
    if (got < min) begin
      n_err++;
      $display("FAIL %s got=%0d want>=%0d", name, got, min);
    end
  endtask

  // FWFT FIFO models: pop on the edge where rd_en was high, then refresh outputs.
  initial forever begin
    @(posedge clk);
    p0 = s0_rd;
    p1 = s1_rd;
    #1;
    if (p0 && q0.size() > 0) void'(q0.pop_front());
    if (p1 && q1.size() > 0) void'(q1.pop_front());
    s0_empty = (q0.size() == 0);
    s0_dout  = (q0.size() > 0) ? q0[0] : IDLE_W;
    s1_empty = hold1 || (q1.size() == 0);
    s1_dout  = (q1.size() > 0) ? q1[0] : IDLE_W;
    @(negedge clk);
    #1;
    s0_empty = (q0.size() == 0);
    s0_dout  = (q0.size() > 0) ? q0[0] : IDLE_W;
    s1_empty = hold1 || (q1.size() == 0);
    s1_dout  = (q1.size() > 0) ? q1[0] : IDLE_W;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame   = 0;
      after_term = 0;
    end else begin
      if (drop_pulse) n_drop++;
      if (!empty) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word got=%h want=none", dout);
        end else begin
          chk("out_word", dout, sb.pop_front());
        end
        if (after_term) begin
          chk_ge("ipg_gap", gap, IPG);
          after_term = 0;
        end
        if (tb_is_start(dout)) in_frame = 1;
        if (tb_is_term(dout)) begin
          in_frame   = 0;
          after_term = 1;
          gap        = 0;
        end
      end else begin
        if (in_frame) n_mid_empty++;
        if (after_term) gap++;
      end
    end
  end

  // n_exp < 0 expects the whole frame; nd < 0 builds a single start+terminate word.
  task automatic push_frame(input int src, input logic [7:0] tag, input int nd, input int n_exp);
    logic [71:0] w[$];
    if (nd < 0) begin
      w.push_back({8'hE1, 8'h07, 8'h07, 8'hFD, tag, 24'h123456, 8'hFB});
    end else begin
      w.push_back({8'h01, tag, 48'h5555_5555_5555, 8'hFB});
      for (int i = 0; i < nd; i++) w.push_back({8'h00, tag, 8'(i), 48'h0123_4567_89AB});
      w.push_back({8'hE0, 8'h07, 8'h07, 8'hFD, tag, 32'hCAFE_F00D});
    end
    foreach (w[i]) begin
      if (src == 0) q0.push_back(w[i]);
      else          q1.push_back(w[i]);
      if (n_exp < 0 || i < n_exp) sb.push_back(w[i]);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout got=%0d/%0d/%0d left want=0", sb.size(), q0.size(), q1.size());
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int busy_cycles;
    repeat (3) @(negedge clk);
    chk("rst_empty", {71'd0, empty}, 72'd1);
    chk("rst_dout", dout, IDLE_W);
    chk("rst_busy_drop", {70'd0, busy, drop_pulse}, 72'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_pop", {70'd0, s0_rd, s1_rd}, 72'd0);

    // Two frames per source: pointer starts at source 0, then alternates.
    push_frame(0, 8'hA0, 2, -1);
    push_frame(1, 8'hB0, 2, -1);
    push_frame(0, 8'hA1, 2, -1);
    push_frame(1, 8'hB1, 2, -1);
    wait_drain();

    // Single 5-word frame: busy spans FRAME (4 cycles) plus the 1-cycle gap.
    push_frame(0, 8'hC0, 3, -1);
    busy_cycles = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    chk("busy_cycles", 72'(busy_cycles), 72'd5);
    wait_drain();

    // Stray word ahead of a one-word frame.
    q0.push_back({8'h00, 64'hDEAD_BEEF_0000_00FB});
    exp_drop++;
    push_frame(0, 8'hD0, -1, -1);
    wait_drain();

    // Underrun: src1 (preferred now) stalls 2 cycles after its second pop.
    push_frame(1, 8'hE0, 3, -1);
    push_frame(0, 8'hE1, 1, -1);
    n_mid_empty = 0;
    repeat (2) @(negedge clk);
    hold1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("src0_not_popped", 72'(q0.size()), 72'd3);
    hold1 = 1'b0;
    wait_drain();
    chk("underrun_empties", 72'(n_mid_empty), 72'd2);

    // Reset mid-frame: only S and D0 leave; the remaining 4 words become strays.
    push_frame(0, 8'hF0, 4, 2);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_empty_dout", {empty, dout}, {1'b1, IDLE_W});
    chk("midrst_rd_en", {70'd0, s0_rd, s1_rd}, 72'd0);
    repeat (2) @(negedge clk);
    chk("midrst_no_pop", 72'(q0.size()), 72'd4);
    rst_n = 1'b1;
    exp_drop += 4;
    push_frame(0, 8'hF1, 1, -1);
    wait_drain();

    chk("drop_pulses", 72'(n_drop), 72'(exp_drop));
    chk("sb_empty", 72'(sb.size()), 72'd0);
`ifdef XGMII_ARB_STATS_EN
    chk("stat_frames0", 72'(f0_cnt), 72'd1);
    chk("stat_frames1", 72'(f1_cnt), 72'd0);
    chk("stat_drop", 72'(d_cnt), 72'd4);
    chk("stat_underrun", 72'(u_cnt), 72'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
